// File: rtl/mode_ctrl_unit.sv
// mode_ctrl_unit: front-end control for the 4-mode LED sequencer.
// Two raw push-buttons are synchronized and debounced. A rising edge of the
// debounced level is a press event. Pause presses toggle the freeze level, and
// mode presses advance the 2-bit mode selector. A free-running divider produces
// the advance strobe for the mode processors.
module mode_ctrl_unit #(
  parameter int TICK_DIV  = 25_000_000,
  parameter int DB_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_pause,
  input  logic       btn_mode,
  output logic       tick,
  output logic       pause,
  output logic [1:0] mode,
  output logic       mode_clear
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int TW  = $clog2(TICK_DIV);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);

  // Bit 0 carries the pause button and bit 1 carries the mode button.
  logic [1:0]     raw;
  logic [1:0]     sync1;
  logic [1:0]     sync2;
  logic [1:0]     db;
  logic [1:0]     db_q;
  logic [1:0]     press;
  logic [DBW-1:0] db_cnt [2];
  logic [TW-1:0]  tick_cnt;
  logic           pause_press;
  logic           mode_press;

  assign raw = {btn_mode, btn_pause};

  // Two-stage synchronizer for both asynchronous buttons.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: a level differing from db for DB_CYCLES consecutive cycles is
  // accepted. Any agreement in between restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      db_q <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // Only rising edges of the debounced level count as presses. Releases are ignored.
  assign press       = db & ~db_q;
  assign pause_press = press[0];
  assign mode_press  = press[1];

  // Mode and pause control. A mode press overrides a pause press in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pause      <= 1'b0;
      mode       <= 2'd0;
      mode_clear <= 1'b0;
    end else begin
      mode_clear <= mode_press;
      if (mode_press) begin
        mode  <= mode + 2'd1;
        pause <= 1'b0;
      end else if (pause_press) begin
        pause <= ~pause;
      end
    end
  end

  // Tick divider. It holds while paused and restarts its period on a mode change.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (mode_press) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (pause) begin
      tick     <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
      tick     <= 1'b0;
    end
  end

endmodule

// File: doc/mode_ctrl_unit.md
# mode_ctrl_unit

Front-end control stage for the 4-mode LED sequencer. It turns two raw push-buttons into a debounced pause toggle and a 2-bit mode selector, and it generates the divided-clock `tick` strobe. Its outputs (`tick`, `pause`, `mode`, `mode_clear`) drive the four mode processors and the LED output multiplexer directly.

## Interface
- `TICK_DIV`, default 25_000_000: `tick` period in `clk` cycles. The default gives 0.5 s at 50 MHz. Minimum value is 2.
- `DB_CYCLES`, default 500_000: number of consecutive cycles a synchronized button level must differ from the debounced level before it is accepted. Minimum value is 2.
- `clk`  in  1  system clock; the block has a single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `btn_pause`  in  1  raw pause button, active-high, asynchronous to `clk`.
- `btn_mode`  in  1  raw mode button, active-high, asynchronous to `clk`.
- `tick`  out  1  one-cycle advance strobe for the mode processors.
- `pause`  out  1  freeze level for the mode processors; 1 = paused.
- `mode`  out  2  selected mode, 0..3.
- `mode_clear`  out  1  one-cycle pulse on every mode change; mode processors restart on it.

## Operation
- **Synchronizer:** each button passes through a 2-FF synchronizer. The synchronizer registers reset to 0.
- **Debouncer (one per button):**
  - Each button has a counter and a stable level `db`.
  - If the synchronized level equals `db`, the counter clears.
  - Otherwise the counter increments. When it reaches `DB_CYCLES-1` while still differing, `db` flips and the counter clears.
  - Any glitch shorter than `DB_CYCLES` cycles is discarded.
- **Press event:** a one-cycle internal pulse on each rising edge of `db`. Releases generate no event.
- **Pause:** toggles on each pause-press event.
- **Mode:**
  - On a mode-press event, `mode <= mode+1`, wrapping 3 -> 0.
  - In the same cycle: `mode_clear <= 1` for exactly one cycle, `pause <= 0`, and the tick counter clears to 0.
- **Simultaneous pause and mode press events in the same cycle:** the mode press wins. `pause` ends at 0, `mode` advances, and `mode_clear` pulses.
- **Tick divider:**
  - The counter runs 0..`TICK_DIV-1`.
  - When the counter equals `TICK_DIV-1` and `pause`=0, the next edge sets the counter to 0 and `tick` to 1 for one cycle. Otherwise `tick` is 0.
  - While `pause`=1, the counter holds its value and `tick` is 0. On resume, counting continues from the held value with no skipped or extra tick.
- **Reset:** clears everything — synchronizers, debounce counters, `db`, tick counter, `tick`=0, `pause`=0, `mode`=0, `mode_clear`=0.
  - Reset takes effect at the first `clk` edge with `reset`=1, including in the middle of a debounce count or a tick period.
  - A button held through reset is seen as a new press: `db` restarts at 0, so one press event follows once the debounce completes after reset release.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- **Tick after reset:** with reset released before edge 0, the first `tick` is high in cycle `TICK_DIV`. After that, `tick` repeats every `TICK_DIV` cycles while unpaused.
- **Button latency:** a clean raw rising edge sampled at edge k gives `db`=1 at edge k+`DB_CYCLES`+1 (2 sync stages plus the debounce count). `pause`/`mode`/`mode_clear` update at edge k+`DB_CYCLES`+2.
- **Pause takes effect:** from the cycle `pause`=1 is visible, no `tick` occurs. A `tick` already registered in that same cycle may still be high.
- **After a mode change:** `mode_clear` and the new `mode` are visible in the same cycle. The next `tick` follows `TICK_DIV` cycles later.
- **Hold requirement:** a held button produces exactly one event; the next event requires a release followed by a new press. There is no auto-repeat.

## Test plan
Bench parameters: `TICK_DIV`=4, `DB_CYCLES`=3.

1. **Reset and tick cadence.** Hold reset, then release with buttons low. Required: `tick`/`pause`/`mode`/`mode_clear` all 0 during reset; `tick` high in cycles 4, 8, 12, … only.
2. **Clean pause press.** Raise `btn_pause` and hold it for 10 cycles. Required: `pause`=1 exactly 5 cycles after the raw edge (`DB_CYCLES`+2), and no `tick` while paused. Then release and press again. Required: `pause`=0, and the remaining tick-counter cycles elapse before the next `tick`.
3. **Bounce rejection.** Drive `btn_pause` high for 2 cycles, low for 1 cycle, high for 2 cycles, then low. Required: `pause` stays 0 and no event occurs.
4. **Mode cycling.** Give 5 clean mode presses while paused. Required:
   - `mode` sequence 1, 2, 3, 0, 1.
   - Five one-cycle `mode_clear` pulses, each coincident with its `mode` update.
   - `pause` cleared to 0 by the first press.
   - First `tick` 4 cycles after each `mode_clear`.
5. **Simultaneous presses.** Raise both buttons on the same edge while `pause`=0 and `mode`=2. Required: `mode`=3, `mode_clear` pulses once, `pause`=0.
6. **Reset mid-operation.** Pulse reset while `mode`=3, `pause`=1, and `btn_mode` is held mid-debounce. Required: all outputs 0 on the next cycle. Then, with `btn_mode` still held, `mode`=1 with a `mode_clear` pulse 5 cycles after reset is released.
